// File: rtl/sfdbs_err_pkg.sv
// Shared types for the doorbell error capture block: field widths,
// the captured error event record and the capture FSM states.
package sfdbs_err_pkg;

    localparam int CODE_W  = 3;
    localparam int ID_W    = 6;
    localparam int DATA_W  = 32;
    localparam int SLICE_W = 5;
    localparam int GROUP_W = 4;
    localparam int CNT_W   = 16;

    typedef struct packed {
        logic [CODE_W-1:0]  code;
        logic               access;
        logic [ID_W-1:0]    id;
        logic [DATA_W-1:0]  data;
        logic [SLICE_W-1:0] slice_idx;
        logic [GROUP_W-1:0] group_idx;
    } err_event_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_HELD  = 2'd2
    } cap_state_e;

endpackage

// File: rtl/sfdbs_err_rr_arb.sv
// Round-robin arbiter over the legal error requests.
// Ports: clk, reset_n (sync, active-low), req in; gnt_vld/gnt_idx
// winner, multi_req high when more than one source requests.
module sfdbs_err_rr_arb #(
    parameter int NUM_SRC = 2,
    parameter int IDX_W   = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic [NUM_SRC-1:0] req,
    output logic               gnt_vld,
    output logic [IDX_W-1:0]   gnt_idx,
    output logic               multi_req
);

    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic [IDX_W-1:0] k_idx;

    // Search starts at the pointer and wraps; first requester wins.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        k_idx   = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            k_idx = IDX_W'((int'(ptr_q) + i) % NUM_SRC);
            if (!gnt_vld && req[k_idx]) begin
                gnt_vld = 1'b1;
                gnt_idx = k_idx;
            end
        end
    end

    assign multi_req = $countones(req) > 1;

    // Pointer moves just past the winner, only on a grant.
    always_comb begin
        ptr_d = ptr_q;
        if (gnt_vld) begin
            if (gnt_idx == IDX_W'(NUM_SRC - 1))
                ptr_d = '0;
            else
                ptr_d = gnt_idx + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset_n)
            ptr_q <= '0;
        else
            ptr_q <= ptr_d;
    end

endmodule

// File: rtl/sfdbs_err_capture.sv
// Captures doorbell error events into the error_err_log/data/idx
// registers. Ports: clk, reset_n (sync, active-low); per-source
// src_err_* events; code_q/multi_q register readback; *_d/*_enb
// register update values and single-cycle enables; err_irq level.
// Optional macro SFDBS_ERR_CAPTURE_CNT_EN adds err_cnt (16-bit,
// saturating count of accepted legal events).
module sfdbs_err_capture
    import sfdbs_err_pkg::*;
#(
    parameter int NUM_SRC = 2
) (
    input  logic                              clk,
    input  logic                              reset_n,
    input  logic [NUM_SRC-1:0]                src_err_valid,
    input  logic [NUM_SRC-1:0][CODE_W-1:0]    src_err_code,
    input  logic [NUM_SRC-1:0]                src_err_access,
    input  logic [NUM_SRC-1:0][ID_W-1:0]      src_err_id,
    input  logic [NUM_SRC-1:0][DATA_W-1:0]    src_err_data,
    input  logic [NUM_SRC-1:0][SLICE_W-1:0]   src_err_slice_idx,
    input  logic [NUM_SRC-1:0][GROUP_W-1:0]   src_err_group_idx,
    input  logic [CODE_W-1:0]                 code_q,
    input  logic                              multi_q,
    output logic [CODE_W-1:0]                 code_d,
    output logic                              access_d,
    output logic [ID_W-1:0]                   id_d,
    output logic                              multi_d,
    output logic [DATA_W-1:0]                 data_d,
    output logic [SLICE_W-1:0]                slice_idx_d,
    output logic [GROUP_W-1:0]                group_idx_d,
    output logic                              code_enb,
    output logic                              access_enb,
    output logic                              id_enb,
    output logic                              multi_enb,
    output logic                              data_enb,
    output logic                              slice_idx_enb,
    output logic                              group_idx_enb,
    output logic                              err_irq
`ifdef SFDBS_ERR_CAPTURE_CNT_EN
    ,
    output logic [CNT_W-1:0]                  err_cnt
`endif
);

    localparam int IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    logic [NUM_SRC-1:0] legal;
    logic               gnt_vld;
    logic [IDX_W-1:0]   gnt_idx;
    logic               multi_req;
    err_event_t         win_evt;

    logic       stage_vld_q, stage_vld_d;
    logic       stage_oth_q, stage_oth_d;
    err_event_t stage_evt_q, stage_evt_d;
    cap_state_e state_q, state_d;

    logic cap;
    logic mset;

    always_comb begin
        legal = '0;
        for (int i = 0; i < NUM_SRC; i++)
            legal[i] = src_err_valid[i] && (src_err_code[i] != '0);
    end

    sfdbs_err_rr_arb #(
        .NUM_SRC (NUM_SRC),
        .IDX_W   (IDX_W)
    ) u_arb (
        .clk       (clk),
        .reset_n   (reset_n),
        .req       (legal),
        .gnt_vld   (gnt_vld),
        .gnt_idx   (gnt_idx),
        .multi_req (multi_req)
    );

    always_comb begin
        win_evt.code      = src_err_code[gnt_idx];
        win_evt.access    = src_err_access[gnt_idx];
        win_evt.id        = src_err_id[gnt_idx];
        win_evt.data      = src_err_data[gnt_idx];
        win_evt.slice_idx = src_err_slice_idx[gnt_idx];
        win_evt.group_idx = src_err_group_idx[gnt_idx];
    end

    // Losers are never dropped silently: they raise the others flag.
    always_comb begin
        stage_vld_d = gnt_vld;
        stage_evt_d = win_evt;
        stage_oth_d = multi_req;
    end

    // WRITE covers the cycle before the new code_q becomes visible.
    always_comb begin
        state_d = state_q;
        cap     = 1'b0;
        mset    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (code_q != '0) begin
                    state_d = ST_HELD;
                    mset    = stage_vld_q && !multi_q;
                end else if (stage_vld_q) begin
                    cap     = 1'b1;
                    state_d = ST_WRITE;
                end
            end
            ST_WRITE: begin
                mset    = stage_vld_q;
                state_d = ST_HELD;
            end
            ST_HELD: begin
                if (code_q == '0) begin
                    cap     = stage_vld_q;
                    state_d = stage_vld_q ? ST_WRITE : ST_IDLE;
                end else begin
                    mset = stage_vld_q && !multi_q;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        code_enb      = cap;
        access_enb    = cap;
        id_enb        = cap;
        data_enb      = cap;
        slice_idx_enb = cap;
        group_idx_enb = cap;
        multi_enb     = (cap && stage_oth_q) || mset;
        multi_d       = multi_enb;
        code_d        = cap ? stage_evt_q.code      : '0;
        access_d      = cap ? stage_evt_q.access    : 1'b0;
        id_d          = cap ? stage_evt_q.id        : '0;
        data_d        = cap ? stage_evt_q.data      : '0;
        slice_idx_d   = cap ? stage_evt_q.slice_idx : '0;
        group_idx_d   = cap ? stage_evt_q.group_idx : '0;
    end

    assign err_irq = code_q != '0;

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= ST_IDLE;
            stage_vld_q <= 1'b0;
            stage_oth_q <= 1'b0;
            stage_evt_q <= '0;
        end else begin
            state_q     <= state_d;
            stage_vld_q <= stage_vld_d;
            stage_oth_q <= stage_oth_d;
            stage_evt_q <= stage_evt_d;
        end
    end

`ifdef SFDBS_ERR_CAPTURE_CNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W:0]   cnt_sum;

    always_comb begin
        cnt_sum = {1'b0, cnt_q} + (CNT_W+1)'($countones(legal));
        cnt_d   = cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (!reset_n)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

    assign err_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_sfdbs_err_capture.sv
// Self-checking bench for sfdbs_err_capture with a register model.
// Per-cycle expected outputs go through a scoreboard queue.
module tb_sfdbs_err_capture;
    import sfdbs_err_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              reset_n;
    logic [1:0]        src_err_valid;
    logic [1:0][2:0]   src_err_code;
    logic [1:0]        src_err_access;
    logic [1:0][5:0]   src_err_id;
    logic [1:0][31:0]  src_err_data;
    logic [1:0][4:0]   src_err_slice_idx;
    logic [1:0][3:0]   src_err_group_idx;
    logic [2:0]        code_q = '0;
    logic              multi_q = 1'b0;
    logic [2:0]        code_d;
    logic              access_d, multi_d;
    logic [5:0]        id_d;
    logic [31:0]       data_d;
    logic [4:0]        slice_idx_d;
    logic [3:0]        group_idx_d;
    logic              code_enb, access_enb, id_enb, multi_enb;
    logic              data_enb, slice_idx_enb, group_idx_enb;
    logic              err_irq;
`ifdef SFDBS_ERR_CAPTURE_CNT_EN
    logic [15:0]       err_cnt;
`endif

    logic       sw_we = 1'b0;
    logic [2:0] sw_code = '0;
    logic       sw_multi = 1'b0;

    sfdbs_err_capture #(.NUM_SRC(2)) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .src_err_valid     (src_err_valid),
        .src_err_code      (src_err_code),
        .src_err_access    (src_err_access),
        .src_err_id        (src_err_id),
        .src_err_data      (src_err_data),
        .src_err_slice_idx (src_err_slice_idx),
        .src_err_group_idx (src_err_group_idx),
        .code_q            (code_q),
        .multi_q           (multi_q),
        .code_d            (code_d),
        .access_d          (access_d),
        .id_d              (id_d),
        .multi_d           (multi_d),
        .data_d            (data_d),
        .slice_idx_d       (slice_idx_d),
        .group_idx_d       (group_idx_d),
        .code_enb          (code_enb),
        .access_enb        (access_enb),
        .id_enb            (id_enb),
        .multi_enb         (multi_enb),
        .data_enb          (data_enb),
        .slice_idx_enb     (slice_idx_enb),
        .group_idx_enb     (group_idx_enb),
        .err_irq           (err_irq)
`ifdef SFDBS_ERR_CAPTURE_CNT_EN
        ,
        .err_cnt           (err_cnt)
`endif
    );

    // Register block: software write has priority over hardware.
    always @(posedge clk) begin
        if (sw_we) begin
            code_q  <= sw_code;
            multi_q <= sw_multi;
        end else begin
            if (code_enb)  code_q  <= code_d;
            if (multi_enb) multi_q <= multi_d;
        end
    end

    typedef struct packed {
        logic [6:0]  enb;
        logic [2:0]  code;
        logic        access;
        logic [5:0]  id;
        logic        multi;
        logic [31:0] data;
        logic [4:0]  slice;
        logic [3:0]  group;
        logic        irq;
    } obs_t;

    typedef struct packed {
        logic       rst_n;
        logic [1:0] vld;
        err_event_t e0;
        err_event_t e1;
        logic       sw;
        logic [2:0] sw_code;
        logic       sw_multi;
    } stim_t;

    localparam err_event_t EV_A = '{code: 3'd3, access: 1'b1,
        id: 6'h15, data: 32'hDEADBEEF, slice_idx: 5'd7, group_idx: 4'd2};
    localparam err_event_t EV_B = '{code: 3'd5, access: 1'b0,
        id: 6'h2A, data: 32'h12345678, slice_idx: 5'h1F, group_idx: 4'hF};
    localparam err_event_t EV_Z = '{code: 3'd0, access: 1'b1,
        id: 6'h3F, data: 32'hCAFEF00D, slice_idx: 5'd3, group_idx: 4'd1};
    localparam err_event_t EV_0 = '0;

    obs_t exp_q[$];
    int   n_cmp = 0;
    int   n_fail = 0;
    int   exp_cnt = 0;

    function automatic obs_t x_none(logic irq);
        obs_t o;
        o = '0;
        o.irq = irq;
        return o;
    endfunction

    function automatic obs_t x_multi(logic irq);
        obs_t o;
        o = '0;
        o.enb = 7'b0001000;
        o.multi = 1'b1;
        o.irq = irq;
        return o;
    endfunction

    function automatic obs_t x_cap(err_event_t e, logic m, logic irq);
        obs_t o;
        o.enb = {3'b111, m, 3'b111};
        o.code = e.code;
        o.access = e.access;
        o.id = e.id;
        o.multi = m;
        o.data = e.data;
        o.slice = e.slice_idx;
        o.group = e.group_idx;
        o.irq = irq;
        return o;
    endfunction

    function automatic obs_t sample();
        obs_t o;
        o.enb = {code_enb, access_enb, id_enb, multi_enb,
                 data_enb, slice_idx_enb, group_idx_enb};
        o.code = code_d;
        o.access = access_d;
        o.id = id_d;
        o.multi = multi_d;
        o.data = data_d;
        o.slice = slice_idx_d;
        o.group = group_idx_d;
        o.irq = err_irq;
        return o;
    endfunction

    function automatic stim_t mk(logic [1:0] v, err_event_t a,
                                 err_event_t b);
        stim_t s;
        s = '0;
        s.rst_n = 1'b1;
        s.vld = v;
        s.e0 = a;
        s.e1 = b;
        return s;
    endfunction

    function automatic stim_t mk_sw(logic [2:0] c, logic m);
        stim_t s;
        s = mk(2'b00, EV_0, EV_0);
        s.sw = 1'b1;
        s.sw_code = c;
        s.sw_multi = m;
        return s;
    endfunction

    task automatic apply(stim_t s);
        logic [1:0] lg;
        reset_n = s.rst_n;
        src_err_valid = s.vld;
        src_err_code[0] = s.e0.code;
        src_err_code[1] = s.e1.code;
        src_err_access[0] = s.e0.access;
        src_err_access[1] = s.e1.access;
        src_err_id[0] = s.e0.id;
        src_err_id[1] = s.e1.id;
        src_err_data[0] = s.e0.data;
        src_err_data[1] = s.e1.data;
        src_err_slice_idx[0] = s.e0.slice_idx;
        src_err_slice_idx[1] = s.e1.slice_idx;
        src_err_group_idx[0] = s.e0.group_idx;
        src_err_group_idx[1] = s.e1.group_idx;
        sw_we = s.sw;
        sw_code = s.sw_code;
        sw_multi = s.sw_multi;
        lg = s.vld & {s.e1.code != 3'd0, s.e0.code != 3'd0};
        if (!s.rst_n)
            exp_cnt = 0;
        else
            exp_cnt = exp_cnt + $countones(lg);
        if (exp_cnt > 65535)
            exp_cnt = 65535;
    endtask

    task automatic test_reset();
        stim_t s[$];
        obs_t  x[$];
        obs_t  o, e;
        stim_t t;
        t = mk_sw(3'd0, 1'b0);
        t.rst_n = 1'b0;
        s.push_back(t); x.push_back(x_none(1'b0));
        t = mk(2'b00, EV_0, EV_0);
        t.rst_n = 1'b0;
        s.push_back(t); x.push_back(x_none(1'b0));
        s.push_back(mk(2'b00, EV_0, EV_0)); x.push_back(x_none(1'b0));
        for (int c = 0; c < s.size(); c++) begin
            apply(s[c]);
            exp_q.push_back(x[c]);
            @(posedge clk); #1;
            o = sample();
            e = exp_q.pop_front();
            n_cmp++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL reset c%0d: got %h want %h", c, o, e);
            end
        end
    endtask

    task automatic test_rr_tie();
        stim_t s[$];
        obs_t  x[$];
        obs_t  o, e;
        s.push_back(mk(2'b11, EV_A, EV_B)); x.push_back(x_cap(EV_A, 1, 0));
        s.push_back(mk(2'b00, EV_0, EV_0)); x.push_back(x_none(1'b1));
        s.push_back(mk_sw(3'd0, 1'b0));     x.push_back(x_none(1'b0));
        s.push_back(mk(2'b11, EV_A, EV_B)); x.push_back(x_cap(EV_B, 1, 0));
        s.push_back(mk(2'b00, EV_0, EV_0)); x.push_back(x_none(1'b1));
        s.push_back(mk_sw(3'd0, 1'b0));     x.push_back(x_none(1'b0));
        s.push_back(mk(2'b00, EV_0, EV_0)); x.push_back(x_none(1'b0));
        for (int c = 0; c < s.size(); c++) begin
            apply(s[c]);
            exp_q.push_back(x[c]);
            @(posedge clk); #1;
            o = sample();
            e = exp_q.pop_front();
            n_cmp++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL rr_tie c%0d: got %h want %h", c, o, e);
            end
        end
    endtask

    task automatic test_single();
        stim_t s[$];
        obs_t  x[$];
        obs_t  o, e;
        s.push_back(mk(2'b01, EV_A, EV_0)); x.push_back(x_cap(EV_A, 0, 0));
        s.push_back(mk(2'b00, EV_0, EV_0)); x.push_back(x_none(1'b1));
        s.push_back(mk(2'b00, EV_0, EV_0)); x.push_back(x_none(1'b1));
        s.push_back(mk_sw(3'd0, 1'b0));     x.push_back(x_none(1'b0));
        s.push_back(mk(2'b00, EV_0, EV_0)); x.push_back(x_none(1'b0));
        for (int c = 0; c < s.size(); c++) begin
            apply(s[c]);
            exp_q.push_back(x[c]);
            @(posedge clk); #1;
            o = sample();
            e = exp_q.pop_front();
            n_cmp++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL single c%0d: got %h want %h", c, o, e);
            end
        end
    endtask

    task automatic test_held_multi();
        stim_t s[$];
        obs_t  x[$];
        obs_t  o, e;
        s.push_back(mk_sw(3'd2, 1'b0));     x.push_back(x_none(1'b1));
        s.push_back(mk(2'b00, EV_0, EV_0)); x.push_back(x_none(1'b1));
        s.push_back(mk(2'b10, EV_0, EV_B)); x.push_back(x_multi(1'b1));
        s.push_back(mk(2'b10, EV_0, EV_B)); x.push_back(x_none(1'b1));
        s.push_back(mk(2'b00, EV_0, EV_0)); x.push_back(x_none(1'b1));
        s.push_back(mk_sw(3'd0, 1'b0));     x.push_back(x_none(1'b0));
        s.push_back(mk(2'b00, EV_0, EV_0)); x.push_back(x_none(1'b0));
        for (int c = 0; c < s.size(); c++) begin
            apply(s[c]);
            exp_q.push_back(x[c]);
            @(posedge clk); #1;
            o = sample();
            e = exp_q.pop_front();
            n_cmp++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL held_multi c%0d: got %h want %h", c, o, e);
            end
        end
    endtask

    task automatic test_clear_capture();
        stim_t s[$];
        obs_t  x[$];
        obs_t  o, e;
        stim_t t;
        s.push_back(mk_sw(3'd4, 1'b0));     x.push_back(x_none(1'b1));
        s.push_back(mk(2'b00, EV_0, EV_0)); x.push_back(x_none(1'b1));
        t = mk_sw(3'd0, 1'b0);
        t.vld = 2'b01;
        t.e0 = EV_A;
        s.push_back(t);                     x.push_back(x_cap(EV_A, 0, 0));
        s.push_back(mk(2'b00, EV_0, EV_0)); x.push_back(x_none(1'b1));
        s.push_back(mk_sw(3'd0, 1'b0));     x.push_back(x_none(1'b0));
        s.push_back(mk(2'b00, EV_0, EV_0)); x.push_back(x_none(1'b0));
        for (int c = 0; c < s.size(); c++) begin
            apply(s[c]);
            exp_q.push_back(x[c]);
            @(posedge clk); #1;
            o = sample();
            e = exp_q.pop_front();
            n_cmp++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL clear_cap c%0d: got %h want %h", c, o, e);
            end
        end
    endtask

    task automatic test_illegal();
        stim_t s[$];
        obs_t  x[$];
        obs_t  o, e;
        s.push_back(mk(2'b01, EV_Z, EV_0)); x.push_back(x_none(1'b0));
        s.push_back(mk(2'b00, EV_0, EV_0)); x.push_back(x_none(1'b0));
        for (int c = 0; c < s.size(); c++) begin
            apply(s[c]);
            exp_q.push_back(x[c]);
            @(posedge clk); #1;
            o = sample();
            e = exp_q.pop_front();
            n_cmp++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL illegal c%0d: got %h want %h", c, o, e);
            end
        end
`ifdef SFDBS_ERR_CAPTURE_CNT_EN
        n_cmp++;
        if (err_cnt !== 16'(exp_cnt)) begin
            n_fail++;
            $display("FAIL illegal_cnt: got %0d want %0d", err_cnt, exp_cnt);
        end
`endif
    endtask

    task automatic test_back_to_back();
        stim_t s[$];
        obs_t  x[$];
        obs_t  o, e;
        s.push_back(mk(2'b01, EV_A, EV_0)); x.push_back(x_cap(EV_A, 0, 0));
        s.push_back(mk(2'b10, EV_0, EV_B)); x.push_back(x_multi(1'b1));
        s.push_back(mk(2'b01, EV_A, EV_0)); x.push_back(x_none(1'b1));
        s.push_back(mk(2'b00, EV_0, EV_0)); x.push_back(x_none(1'b1));
        s.push_back(mk_sw(3'd0, 1'b0));     x.push_back(x_none(1'b0));
        s.push_back(mk(2'b00, EV_0, EV_0)); x.push_back(x_none(1'b0));
        for (int c = 0; c < s.size(); c++) begin
            apply(s[c]);
            exp_q.push_back(x[c]);
            @(posedge clk); #1;
            o = sample();
            e = exp_q.pop_front();
            n_cmp++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL b2b c%0d: got %h want %h", c, o, e);
            end
        end
    endtask

    task automatic test_reset_mid();
        stim_t s[$];
        obs_t  x[$];
        obs_t  o, e;
        stim_t t;
        s.push_back(mk(2'b01, EV_A, EV_0)); x.push_back(x_cap(EV_A, 0, 0));
        t = mk_sw(3'd0, 1'b0);
        t.rst_n = 1'b0;
        t.vld = 2'b01;
        t.e0 = EV_A;
        s.push_back(t);                     x.push_back(x_none(1'b0));
        s.push_back(mk(2'b00, EV_0, EV_0)); x.push_back(x_none(1'b0));
        s.push_back(mk(2'b11, EV_A, EV_B)); x.push_back(x_cap(EV_A, 1, 0));
        s.push_back(mk(2'b00, EV_0, EV_0)); x.push_back(x_none(1'b1));
        s.push_back(mk_sw(3'd0, 1'b0));     x.push_back(x_none(1'b0));
        s.push_back(mk(2'b00, EV_0, EV_0)); x.push_back(x_none(1'b0));
        for (int c = 0; c < s.size(); c++) begin
            apply(s[c]);
            exp_q.push_back(x[c]);
            @(posedge clk); #1;
            o = sample();
            e = exp_q.pop_front();
            n_cmp++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL reset_mid c%0d: got %h want %h", c, o, e);
            end
        end
    endtask

`ifdef SFDBS_ERR_CAPTURE_CNT_EN
    task automatic test_count();
        n_cmp++;
        if (err_cnt !== 16'd2) begin
            n_fail++;
            $display("FAIL cnt_start: got %0d want 2", err_cnt);
        end
        for (int i = 0; i < 35000; i++) begin
            apply(mk(2'b11, EV_A, EV_B));
            @(posedge clk); #1;
            if (i == 99) begin
                n_cmp++;
                if (err_cnt !== 16'd202) begin
                    n_fail++;
                    $display("FAIL cnt_mid: got %0d want 202", err_cnt);
                end
            end
        end
        apply(mk(2'b00, EV_0, EV_0));
        @(posedge clk); #1;
        n_cmp++;
        if (err_cnt !== 16'(exp_cnt)) begin
            n_fail++;
            $display("FAIL cnt_model: got %0d want %0d", err_cnt, exp_cnt);
        end
        n_cmp++;
        if (err_cnt !== 16'hFFFF) begin
            n_fail++;
            $display("FAIL cnt_sat: got %h want ffff", err_cnt);
        end
    endtask
`endif

    initial begin
        apply(mk(2'b00, EV_0, EV_0));
        reset_n = 1'b0;
        test_reset();
        test_rr_tie();
        test_single();
        test_held_multi();
        test_clear_capture();
        test_illegal();
        test_back_to_back();
        test_reset_mid();
`ifdef SFDBS_ERR_CAPTURE_CNT_EN
        test_count();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_fail);
        $finish;
    end

endmodule
